// File: rtl/input_sequencer_pkg.sv
// Shared state encoding and default immediate for the input sequencer.
package input_sequencer_pkg;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    ENTER_C = 3'd2,
    ENTER_D = 3'd3,
    PRESENT = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_IMM_VAL = 21;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debouncer for an active-low button;
// emits a one-cycle press pulse when the debounced level falls.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_MAX) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= r_level;  // old level 1 means this is a 1->0 edge
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/input_sequencer.sv
// Switch-entry sequencer: captures fields A/B/C (and D when INPUT_IMM_EN is
// defined) on debounced button presses, then presents them with valid/ready.
module input_sequencer
  import input_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SW      = 4,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned DEFAULT_IMM = DEFAULT_IMM_VAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw,
  input  logic              btn_n,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_a,
  output logic [ADDR_W-1:0] out_b,
  output logic [ADDR_W-1:0] out_c,
  output logic [DATA_W-1:0] out_d,
  output logic [2:0]        step
);

  logic [NUM_SW-2:0] r_sw_meta;
  logic [NUM_SW-2:0] r_sw_sync;
  logic              w_unused_msb;
  logic              w_press;
  logic [ADDR_W-1:0] w_addr_val;

  state_e            r_state;
  logic              r_valid;
  logic [ADDR_W-1:0] r_a;
  logic [ADDR_W-1:0] r_b;
  logic [ADDR_W-1:0] r_c;
`ifdef INPUT_IMM_EN
  logic [DATA_W-1:0] r_d;
`endif

  assign w_unused_msb = sw[NUM_SW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw[NUM_SW-2:0];
      r_sw_sync <= r_sw_meta;
    end
  end

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn_n(btn_n),
    .o_press(w_press)
  );

  assign w_addr_val = ADDR_W'(r_sw_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ENTER_A;
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
`ifdef INPUT_IMM_EN
      r_d     <= '0;
`endif
    end else if (abort) begin
      // abort outranks a press; a handshake in this cycle has already transferred
      r_state <= ENTER_A;
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
`ifdef INPUT_IMM_EN
      r_d     <= '0;
`endif
    end else begin
      case (r_state)
        ENTER_A: if (w_press) begin
          r_a     <= w_addr_val;
          r_state <= ENTER_B;
        end
        ENTER_B: if (w_press) begin
          r_b     <= w_addr_val;
          r_state <= ENTER_C;
        end
        ENTER_C: if (w_press) begin
          r_c     <= w_addr_val;
`ifdef INPUT_IMM_EN
          r_state <= ENTER_D;
`else
          r_state <= PRESENT;
          r_valid <= 1'b1;
`endif
        end
`ifdef INPUT_IMM_EN
        ENTER_D: if (w_press) begin
          r_d     <= DATA_W'(r_sw_sync);
          r_state <= PRESENT;
          r_valid <= 1'b1;
        end
`endif
        PRESENT: if (out_ready) begin
          r_state <= ENTER_A;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= ENTER_A;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_c     = r_c;
  assign step      = r_state;
`ifdef INPUT_IMM_EN
  assign out_d     = r_d;
`else
  assign out_d     = DATA_W'(DEFAULT_IMM);
`endif

endmodule

// File: tb/tb_input_sequencer.sv
// Scoreboard bench for input_sequencer (DEB_CYCLES=4); covers the
// INPUT_IMM_EN build when that macro is defined.
module tb_input_sequencer;

  localparam int DEB = 4;
`ifdef INPUT_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  c;
    logic [31:0] d;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sw;
  logic        btn_n;
  logic        abort;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_a;
  logic [4:0]  out_b;
  logic [4:0]  out_c;
  logic [31:0] out_d;
  logic [2:0]  step;

  int n_total = 0;
  int n_pass  = 0;
  int n_xfer  = 0;
  int n_unstable = 0;
  bit watch = 1'b0;
  bundle_t watch_exp;
  bundle_t exp_q[$];

  input_sequencer #(
    .NUM_SW(4), .ADDR_W(5), .DATA_W(32), .DEB_CYCLES(DEB), .DEFAULT_IMM(21)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_n(btn_n), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .out_a(out_a),
    .out_b(out_b), .out_c(out_c), .out_d(out_d), .step(step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_d(input logic [3:0] v);
    return IMM_EN ? {29'd0, v[2:0]} : 32'd21;
  endfunction

  // Press timing: low at E0, synced by E2, four differing cycles E3..E6,
  // pulse during the cycle after E6, state advances at E7.
  task automatic press(input logic [3:0] v);
    sw = v;
    tick(3);
    btn_n = 1'b0;
    tick(10);
    btn_n = 1'b1;
    tick(10);
  endtask

  task automatic fill(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    press(a);
    press(b);
    press(c);
    if (IMM_EN) press(d);
  endtask

  task automatic wait_xfer(input int target);
    for (int i = 0; i < 40 && n_xfer < target; i++) tick(1);
    check("xfer_count", n_xfer, target);
  endtask

  // Monitor: every handshake seen pops one expected bundle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        bundle_t e;
        e = exp_q.pop_front();
        check("xfer_a", out_a, e.a);
        check("xfer_b", out_b, e.b);
        check("xfer_c", out_c, e.c);
        check("xfer_d", out_d, e.d);
      end
      n_xfer++;
    end
  end

  always @(negedge clk) begin
    if (watch && (out_a !== watch_exp.a || out_b !== watch_exp.b || out_c !== watch_exp.c ||
                  out_d !== watch_exp.d || out_valid !== 1'b1 || step !== 3'd4))
      n_unstable++;
  end

  initial begin
    rst_n = 1'b0; sw = 4'd0; btn_n = 1'b1; abort = 1'b0; out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_step", step, 3'd0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_a", out_a, 5'd0);
    check("rst_b", out_b, 5'd0);
    check("rst_c", out_c, 5'd0);
    check("rst_d", out_d, IMM_EN ? 32'd0 : 32'd21);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Full entry with out_ready held high (ready ignored while entering)
    out_ready = 1'b1;
    if (IMM_EN) exp_q.push_back('{a: 5'd1, b: 5'd2, c: 5'd3, d: 32'd6});
    else        exp_q.push_back('{a: 5'd3, b: 5'd5, c: 5'd7, d: 32'd21});
    press(IMM_EN ? 4'b0001 : 4'b0011);
    @(negedge clk);
    check("first_step", step, 3'd1);
    check("first_a", out_a, IMM_EN ? 5'd1 : 5'd3);
    check("first_valid", out_valid, 1'b0);
    tick(1);
    if (IMM_EN) begin
      press(4'b0010); press(4'b0011); press(4'b0110);
    end else begin
      press(4'b0101); press(4'b0111);
    end
    wait_xfer(1);
    @(negedge clk);
    check("after_xfer_step", step, 3'd0);
    check("after_xfer_valid", out_valid, 1'b0);
    tick(1);

    // Bouncing button: 2-cycle toggles never qualify, then one solid press
    out_ready = 1'b0;
    sw = 4'b1010;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      btn_n = ~btn_n;
      tick(2);
    end
    @(negedge clk);
    check("bounce_step", step, 3'd0);
    tick(1);
    btn_n = 1'b0;
    tick(12);
    check("bounce_press_step", step, 3'd1);
    check("bounce_press_a", out_a, 5'd2);
    btn_n = 1'b1;
    tick(12);
    check("release_no_press", step, 3'd1);

    // Abort coinciding with the press pulse
    press(4'b0011);
    @(negedge clk);
    check("pre_abort_step", step, 3'd2);
    check("pre_abort_b", out_b, 5'd3);
    tick(1);
    sw = 4'b0101;
    tick(3);
    btn_n = 1'b0;
    tick(6);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge clk);
    check("abort_step", step, 3'd0);
    check("abort_a", out_a, 5'd0);
    check("abort_b", out_b, 5'd0);
    check("abort_c", out_c, 5'd0);
    check("abort_d", out_d, IMM_EN ? 32'd0 : 32'd21);
    tick(1);
    btn_n = 1'b1;
    tick(10);
    check("abort_hold_step", step, 3'd0);

    // Backpressure: PRESENT held with ready low, presses ignored
    fill(4'b0001, 4'b0010, 4'b0100, 4'b0101);
    @(negedge clk);
    check("bp_step", step, 3'd4);
    check("bp_valid", out_valid, 1'b1);
    check("bp_c", out_c, 5'd4);
    check("bp_d", out_d, exp_d(4'b0101));
    watch_exp = '{a: 5'd1, b: 5'd2, c: 5'd4, d: exp_d(4'b0101)};
    watch = 1'b1;
    tick(1);
    press(4'b0111);
    press(4'b0110);
    tick(10);
    watch = 1'b0;
    check("bp_unstable_cycles", n_unstable, 0);
    exp_q.push_back(watch_exp);
    out_ready = 1'b1;
    wait_xfer(2);
    @(negedge clk);
    check("bp_done_step", step, 3'd0);
    tick(1);
    out_ready = 1'b0;

    // Asynchronous reset in ENTER_C discards partial fields
    press(4'b0001);
    press(4'b0010);
    out_ready = 1'b1;
    @(negedge clk);
    check("pre_rst_step", step, 3'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_step", step, 3'd0);
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_a", out_a, 5'd0);
    check("async_rst_b", out_b, 5'd0);
    check("async_rst_d", out_d, IMM_EN ? 32'd0 : 32'd21);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("post_rst_step", step, 3'd0);
    check("post_rst_no_xfer", n_xfer, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/input_sequencer.md
INPUT_SEQUENCER -- requirements
Module: input_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_SW, 4: switch count; field value comes from sw[NUM_SW-2:0].
- ADDR_W, 5: width of the register-address fields.
- DATA_W, 32: immediate width.
- DEB_CYCLES, 16: debounce stability count, at least 2.
- DEFAULT_IMM, 21: constant immediate.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- sw, in, NUM_SW: raw asynchronous switches.
- btn_n, in, 1: raw asynchronous active-low enter button.
- abort, in, 1: synchronous clear of the entry in progress.
- out_ready, in, 1: consumer accepts the bundle.
- out_valid, out, 1: bundle A/B/C/D is valid.
- out_a / out_b / out_c, out, ADDR_W each: captured register fields.
- out_d, out, DATA_W: immediate.
- step, out, 3: current state encoding, for LEDs.

REQ-003 The block SHALL use one clock; reset SHALL be asynchronous, active-low, on rst_n.

Function
REQ-004 sw and btn_n SHALL each pass through a two-flop synchronizer before any other use.
REQ-005 The debounced button level SHALL change only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-006 A press SHALL be a single-cycle pulse raised in the cycle the debounced level goes 1->0; release generates nothing.
REQ-007 The field value SHALL be sw_sync[NUM_SW-2:0], zero-extended or truncated to the target width.
REQ-008 States SHALL be ENTER_A (0), ENTER_B (1), ENTER_C (2), ENTER_D (3, macro only) and PRESENT (4).
REQ-009 A press in ENTER_A, ENTER_B or ENTER_C SHALL load out_a, out_b or out_c respectively and advance to the next state; the new value is visible the following cycle.
REQ-010 With no press, the state and fields SHALL hold.
REQ-011 In PRESENT, out_valid SHALL be 1; when out_valid and out_ready are both 1, the bundle transfers and the state returns to ENTER_A next cycle.
REQ-012 out_a, out_b, out_c and out_d SHALL stay stable while out_valid is 1 and out_ready is 0.
REQ-013 Presses in PRESENT SHALL be ignored; they are not queued.
REQ-014 abort SHALL return the state to ENTER_A and clear out_a, out_b and out_c to 0 next cycle. abort wins over a simultaneous press. If abort coincides with valid&ready, the transfer still counts.
REQ-015 out_ready SHALL be ignored outside PRESENT.
REQ-016 sw[NUM_SW-1] SHALL be unused.

Reset
REQ-017 While rst_n is 0, the block SHALL hold: state ENTER_A, step 0, out_valid 0, out_a/b/c 0, out_d at its REQ-019/020 value, debounced level 1, debounce counter 0, synchronizers 1 for btn_n and 0 for sw.
REQ-018 Reset asserted mid-entry or mid-handshake SHALL discard all partial fields; there is no transfer on release.

Configuration
REQ-019 With INPUT_IMM_EN defined:
- The ENTER_C press advances to ENTER_D.
- A press in ENTER_D loads out_d with the zero-extended switch value and enters PRESENT.
- out_d resets to 0, and abort clears it.
REQ-020 Without INPUT_IMM_EN:
- ENTER_C advances directly to PRESENT.
- out_d is the constant DEFAULT_IMM.
- State encoding 3 is never reached.

Structure
REQ-021 A shared package SHALL hold the state encoding constants and the DEFAULT_IMM value.
REQ-022 The synchronizer and debouncer SHALL form the sub-module btn_debounce, parametrised by DEB_CYCLES and outputting the press pulse. The sw synchronizer stays in the top level.

Verification
REQ-023 Bench (DEB_CYCLES=4, macro off): set sw=4'b0011 and press; set sw=4'b0101 and press; set sw=4'b0111 and press; hold out_ready=1 -> out_valid rises with out_a=3, out_b=5, out_c=7, out_d=21, then returns to ENTER_A.
REQ-024 Bench: toggle btn_n every 2 cycles for 20 cycles, then hold it low -> exactly one press; step goes 0 to 1 once.
REQ-025 Bench: reach PRESENT with out_ready=0 for 10 cycles and press twice -> outputs stable, out_valid stays 1, no state change; raising out_ready completes the transfer.
REQ-026 Bench: after two captures, assert abort in the same cycle as a press -> step=0 and out_a=out_b=0 next cycle.
REQ-027 Bench (macro on): four presses with sw=4'b0001, 4'b0010, 4'b0011, 4'b0110 -> out_d=6 and out_valid=1 after the fourth press.
REQ-028 Bench: assert rst_n=0 during the ENTER_C state -> all outputs at reset values immediately, asynchronously.
